mem_responder: RTL

//  Memory-side responder for the cen/rd/wr/add/din bus that the stimulus benches drive.

---
 rtl/mem_responder_pkg.sv | 34 +++
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_responder_array.sv | 57 +++++
 rtl/mem_responder.sv | 82 ++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: bus op encodings, default widths and the
// per-edge op decoder.
package mem_responder_pkg;

    localparam int unsigned DefAw = 12;
    localparam int unsigned DefDw = 8;
    localparam int unsigned DefCw = 16;
    localparam logic [7:0]  DefUninit = 8'h00;

    typedef enum logic [2:0] {
        OpIdle,
        OpRd,
        OpWr,
        OpErr,
        OpDis
    } op_e;

    // Unknown strobes fall through to the default arm, so X/Z reads as a protocol error.
    function automatic op_e decode_op(input logic cen, input logic rd, input logic wr);
        op_e op;
        if (cen == 1'b1) begin
            op = OpDis;
        end else begin
            case ({rd, wr})
                2'b00:   op = OpIdle;
                2'b01:   op = OpWr;
                2'b10:   op = OpRd;
                default: op = OpErr;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// cen/rd/wr/add/din request bus with the responder's data, pulse and counter returns.
interface mem_responder_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 16
);
    logic          cen;
    logic          rd;
    logic          wr;
    logic [AW-1:0] add;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          rd_uninit;
    logic          proto_err;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] err_cnt;

    modport master (
        output cen, rd, wr, add, din,
        input  dout, dout_vld, rd_uninit, proto_err, wr_cnt, rd_cnt, err_cnt
    );

    modport slave (
        input  cen, rd, wr, add, din,
        output dout, dout_vld, rd_uninit, proto_err, wr_cnt, rd_cnt, err_cnt
    );
endinterface

// File: rtl/mem_responder_array.sv
// DEPTH x DW storage with per-word written flags, one write port and one registered read port.
module mem_responder_array #(
    parameter int unsigned   AW     = 12,
    parameter int unsigned   DW     = 8,
    parameter logic [DW-1:0] UNINIT = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic          clr_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          miss_o
);
    localparam int unsigned Depth = 2 ** AW;

    logic [DW-1:0]    mem_q [Depth];
    logic [Depth-1:0] valid_q;
    logic [DW-1:0]    rdata_q;
    logic             miss_q;

    // Contents survive reset; only the written flags are cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[addr_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
            miss_q  <= 1'b0;
        end else begin
            miss_q <= 1'b0;
            if (clr_i) begin
                rdata_q <= '0;
            end else if (re_i) begin
                rdata_q <= valid_q[addr_i] ? mem_q[addr_i] : UNINIT;
                miss_q  <= ~valid_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;
    assign miss_o  = miss_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: op decode, registered status pulses and saturating access counters
// around the storage array.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned   AW     = DefAw,
    parameter int unsigned   DW     = DefDw,
    parameter int unsigned   CW     = DefCw,
    parameter logic [DW-1:0] UNINIT = DW'(DefUninit)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mem_responder_if.slave bus
);
    op_e           op;
    logic          we;
    logic          dout_vld_q, dout_vld_d;
    logic          proto_err_q, proto_err_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;

    assign op = decode_op(bus.cen, bus.rd, bus.wr);
    // Reset beats a concurrent write so nothing lands in the array.
    assign we = (op == OpWr) && !rst_i;

    mem_responder_array #(
        .AW     (AW),
        .DW     (DW),
        .UNINIT (UNINIT)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (we),
        .re_i    (op == OpRd),
        .clr_i   (op == OpDis),
        .addr_i  (bus.add),
        .wdata_i (bus.din),
        .rdata_o (bus.dout),
        .miss_o  (bus.rd_uninit)
    );

    always_comb begin
        dout_vld_d  = (op == OpRd);
        proto_err_d = (op == OpErr);
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (op == OpWr && wr_cnt_q != '1) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
        if (op == OpRd && rd_cnt_q != '1) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (op == OpErr && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_vld_q  <= 1'b0;
            proto_err_q <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            dout_vld_q  <= dout_vld_d;
            proto_err_q <= proto_err_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.dout_vld  = dout_vld_q;
    assign bus.proto_err = proto_err_q;
    assign bus.wr_cnt    = wr_cnt_q;
    assign bus.rd_cnt    = rd_cnt_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule
